// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl
// ----------------
// Sequences an I2S microphone front end and packs its PCM stream into
// FRAME_LEN-sample frames held in a two-bank (ping-pong) buffer. Each full
// bank is streamed out over a valid/ready interface.
//
// Ports
//   clk, rst              system clock, asynchronous active-high reset
//   start, stop           one-cycle control pulses
//   i2s_rst               holds the I2S receiver in reset (1 = reset)
//   in_sample, in_valid   PCM sample stream from the I2S receiver
//   out_data, out_valid,
//   out_ready, out_last   frame output stream (out_last = final word)
//   busy                  controller is not IDLE
//   overrun               sticky: a sample was dropped, no free bank
//   frame_count           frames completed since start (wraps)
//   mic_fault             sticky watchdog timeout flag
//
// Build option
//   MIC_CAPTURE_TIMEOUT_EN  adds an in_valid watchdog of TIMEOUT_CYCLES
//                           clocks; without it mic_fault is tied to 0.

module mic_capture_ctrl #(
    parameter int FRAME_LEN      = 256,
    parameter int WARMUP_SAMPLES = 1024,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic        i2s_rst,
    input  logic [15:0] in_sample,
    input  logic        in_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_count,
    output logic        mic_fault
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    // At least one bit wide even when the warm-up is disabled.
    localparam int WU_W  = $clog2(WARMUP_SAMPLES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, STOPPING} state_t;

    state_t            state, state_nxt;
    logic [WU_W-1:0]   wu_cnt;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_bank, rd_bank;
    logic [1:0]        full;
    logic [15:0]       mem [2*FRAME_LEN];

    logic start_ok, run, timeout, wu_done;
    logic wr_en, wr_ok, wr_last, rd_xfer, rd_last;

    assign start_ok = (state == IDLE) && start && !stop;
    assign run      = (state == WARMUP) || (state == CAPTURE);
    assign wu_done  = in_valid && (wu_cnt == WU_W'(WARMUP_SAMPLES - 1));

    // stop (or a timeout) ends capture before the same-cycle sample is taken.
    assign wr_en   = (state == CAPTURE) && in_valid && !stop && !timeout;
    assign wr_ok   = wr_en && !full[wr_bank];
    assign wr_last = wr_ok && (wr_idx == LAST_IDX);
    assign rd_xfer = out_valid && out_ready;
    assign rd_last = rd_xfer && out_last;

`ifdef MIC_CAPTURE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive clock without in_valid.
    assign timeout = run && !in_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            mic_fault <= 1'b0;
        end else begin
            if (start_ok || in_valid || !run)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_W'(1);
            if (start_ok)
                mic_fault <= 1'b0;
            else if (timeout)
                mic_fault <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign mic_fault = 1'b0;
`endif

    // State register
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    // NOTE: state_nxt gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = (WARMUP_SAMPLES == 0) ? CAPTURE : WARMUP;
            WARMUP: begin
                if (stop)         state_nxt = IDLE;
                else if (timeout) state_nxt = STOPPING;
                else if (wu_done) state_nxt = CAPTURE;
            end
            CAPTURE:  if (stop || timeout) state_nxt = STOPPING;
            STOPPING: if (full == 2'b00)   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        i2s_rst = 1'b1;
        busy    = 1'b1;
        case (state)
            IDLE:     busy    = 1'b0;
            WARMUP:   i2s_rst = 1'b0;
            CAPTURE:  i2s_rst = 1'b0;
            default:  i2s_rst = 1'b1;
        endcase
    end

    // Write side: warm-up counting, write pointer, status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wu_cnt      <= '0;
            wr_idx      <= '0;
            wr_bank     <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else if (start_ok) begin
            wu_cnt      <= '0;
            wr_idx      <= '0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (state == WARMUP && in_valid)
                wu_cnt <= wu_cnt + WU_W'(1);
            // Abandoning capture discards the partial frame in place.
            if (state == CAPTURE && (stop || timeout))
                wr_idx <= '0;
            if (wr_en && full[wr_bank])
                overrun <= 1'b1;
            if (wr_ok) begin
                wr_idx <= wr_last ? '0 : wr_idx + IDX_W'(1);
                if (wr_last) begin
                    wr_bank     <= ~wr_bank;
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

    // Bank full flags and read pointer. A bank being filled is never the one
    // being drained, so set and clear never target the same flag together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && wr_bank == 1'(b))
                    full[b] <= 1'b1;
                else if (rd_last && rd_bank == 1'(b))
                    full[b] <= 1'b0;
            end
            if (rd_xfer) begin
                rd_idx <= rd_last ? '0 : rd_idx + IDX_W'(1);
                if (rd_last)
                    rd_bank <= ~rd_bank;
            end
        end
    end

    // NOTE: the sample buffer is deliberately not reset; its contents are
    // only observed once a bank's full flag is set, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[{wr_bank, wr_idx}] <= in_sample;
    end

    // A full bank is never written, so the read word holds steady under stall.
    assign out_valid = full[rd_bank];
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign out_data  = out_valid ? mem[{rd_bank, rd_idx}] : 16'h0000;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Testbench for mic_capture_ctrl (FRAME_LEN=4, WARMUP_SAMPLES=2,
// TIMEOUT_CYCLES=100). Inputs change 1 time unit after the rising edge and
// outputs are sampled there or on the falling edge.

module tb_mic_capture_ctrl;

    localparam int FL = 4;
    localparam int WU = 2;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_sample = '0;
    logic        i2s_rst, out_valid, out_last, busy, overrun, mic_fault;
    logic [15:0] out_data, frame_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {logic last; logic [15:0] data;} word_t;
    word_t got_q[$];

    typedef struct {
        logic        start, stop, iv;
        logic [15:0] smp;
        logic        rdy;
        logic        e_i2s, e_busy, e_valid;
        logic [15:0] e_data;
        logic        e_last;
        logic [15:0] e_fc;
    } vec_t;
    vec_t vecs[12];

    mic_capture_ctrl #(.FRAME_LEN(FL), .WARMUP_SAMPLES(WU), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .i2s_rst(i2s_rst),
        .in_sample(in_sample), .in_valid(in_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .overrun(overrun), .frame_count(frame_count),
        .mic_fault(mic_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1; in_sample = d; tick(); in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic wait_words(input int n, input string name);
        int k = 0;
        while (got_q.size() < n && k < 60) begin tick(); k++; end
        check(name, got_q.size(), n);
    endtask

    task automatic check_words(input string name, input logic [15:0] base, input int n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check({name, "_data"}, got_q[i].data, base + 16'(i));
            check({name, "_last"}, got_q[i].last, (i % FL) == FL - 1);
        end
    endtask

    // Output monitor: collects transfers and checks hold-under-stall.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) got_q.push_back('{out_last, out_data});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Behavioural reference: frames as word queues, outstanding frame count.
    typedef enum {M_IDLE, M_WARM, M_CAP, M_STOP} mmode_t;
    mmode_t      m_mode;
    int          m_warm, m_nfull, m_rdpos;
    logic [15:0] m_part[$];
    logic [15:0] m_pend[$];
    logic        m_ovr;
    logic [15:0] m_fc;

    task automatic model_reset();
        m_mode = M_IDLE; m_warm = 0; m_nfull = 0; m_rdpos = 0;
        m_part.delete(); m_pend.delete(); m_ovr = 1'b0; m_fc = '0;
    endtask

    task automatic model_step(input logic s, p, v, input logic [15:0] d, input logic r);
        int  nfull_pre = m_nfull;
        bit  xfer      = (m_nfull > 0) && r;
        case (m_mode)
            M_IDLE: if (s && !p) begin
                m_mode = (WU == 0) ? M_CAP : M_WARM;
                m_warm = 0; m_part.delete(); m_ovr = 1'b0; m_fc = '0;
            end
            M_WARM: if (p) m_mode = M_IDLE;
                    else if (v) begin
                        m_warm++;
                        if (m_warm == WU) m_mode = M_CAP;
                    end
            M_CAP: if (p) begin
                       m_mode = M_STOP; m_part.delete();
                   end else if (v) begin
                       if (nfull_pre == 2) m_ovr = 1'b1;
                       else begin
                           m_part.push_back(d);
                           if (m_part.size() == FL) begin
                               foreach (m_part[i]) m_pend.push_back(m_part[i]);
                               m_part.delete(); m_nfull++; m_fc++;
                           end
                       end
                   end
            M_STOP: if (nfull_pre == 0) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        if (xfer) begin
            void'(m_pend.pop_front());
            m_rdpos++;
            if (m_rdpos == FL) begin m_rdpos = 0; m_nfull--; end
        end
    endtask

    task automatic compare_model();
        check("rnd_valid", out_valid, m_nfull > 0);
        if (m_nfull > 0) begin
            check("rnd_data", out_data, m_pend[0]);
            check("rnd_last", out_last, m_rdpos == FL - 1);
        end
        check("rnd_i2s_rst", i2s_rst, (m_mode == M_IDLE) || (m_mode == M_STOP));
        check("rnd_busy", busy, m_mode != M_IDLE);
        check("rnd_overrun", overrun, m_ovr);
        check("rnd_frame_count", frame_count, m_fc);
        check("rnd_mic_fault", mic_fault, 1'b0);
    endtask

    initial begin
        //          start stop iv  smp  rdy  i2s busy vld data last fc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h3, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h4, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h6, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3, 1'b0, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h6, 1'b1, 16'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'd1};

        // Reset values
        #12;
        check("rst_i2s_rst", i2s_rst, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_mic_fault", mic_fault, 1'b0);
        @(negedge clk); #1 rst = 1'b0;
        tick();

        // Basic capture: warm-up discard and first frame, table-driven.
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; stop = vecs[i].stop; in_valid = vecs[i].iv;
            in_sample = vecs[i].smp; out_ready = vecs[i].rdy;
            check($sformatf("vec%0d_i2s_rst", i), i2s_rst, vecs[i].e_i2s);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
                check($sformatf("vec%0d_last", i), out_last, vecs[i].e_last);
            end
            check($sformatf("vec%0d_fc", i), frame_count, vecs[i].e_fc);
            tick();
        end
        start = 1'b0; in_valid = 1'b0;

        // Both banks full under stall: overrun, then in-order drain.
        pulse_stop();
        tick();
        check("t2_idle_busy", busy, 1'b0);
        out_ready = 1'b0;
        pulse_start();
        feed(16'h00AA); feed(16'h00BB);
        for (int i = 0; i < 12; i++) feed(16'h0100 + 16'(i));
        check("t2_overrun", overrun, 1'b1);
        check("t2_frame_count", frame_count, 16'd2);
        check("t2_valid", out_valid, 1'b1);
        got_q.delete();
        out_ready = 1'b1;
        wait_words(8, "t2_count");
        check_words("t2", 16'h0100, 8);
        tick();
        check("t2_drained", out_valid, 1'b0);

        // Backpressure: out_ready toggles every cycle.
        got_q.delete();
        for (int k = 0; k < 40; k++) begin
            out_ready = k[0];
            in_valid  = (k < 8);
            in_sample = 16'h0200 + 16'(k);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_words(8, "t3_count");
        check_words("t3", 16'h0200, 8);

        // stop with a partial frame and one full frame pending.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) feed(16'h0300 + 16'(i));
        pulse_stop();
        check("t4_i2s_rst", i2s_rst, 1'b1);
        check("t4_busy", busy, 1'b1);
        check("t4_pending", out_valid, 1'b1);
        got_q.delete();
        out_ready = 1'b1;
        wait_words(4, "t4_count");
        repeat (6) tick();
        check("t4_no_partial", got_q.size(), 4);
        check_words("t4", 16'h0300, 4);
        check("t4_idle_busy", busy, 1'b0);
        check("t4_idle_i2s", i2s_rst, 1'b1);

        // Asynchronous reset mid-frame with out_valid high.
        out_ready = 1'b0;
        pulse_start();
        feed(16'h00AA); feed(16'h00BB);
        for (int i = 0; i < 12; i++) feed(16'h0400 + 16'(i));
        check("t5_pre_valid", out_valid, 1'b1);
        check("t5_pre_overrun", overrun, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_last", out_last, 1'b0);
        check("t5_rst_data", out_data, 16'h0);
        check("t5_rst_i2s", i2s_rst, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_overrun", overrun, 1'b0);
        check("t5_rst_fc", frame_count, 16'd0);
        @(negedge clk); #1 rst = 1'b0;
        got_q.delete();
        tick();
        out_ready = 1'b1;
        pulse_start();
        feed(16'h00AA); feed(16'h00BB);
        for (int i = 0; i < 4; i++) feed(16'h0500 + 16'(i));
        wait_words(4, "t5_count");
        check_words("t5", 16'h0500, 4);
        check("t5_fc", frame_count, 16'd1);

`ifdef MIC_CAPTURE_TIMEOUT_EN
        // Watchdog: no in_valid after start.
        pulse_stop();
        repeat (3) tick();
        check("t6_idle", busy, 1'b0);
        pulse_start();
        repeat (TO - 1) tick();
        check("t6_fault_early", mic_fault, 1'b0);
        tick();
        check("t6_fault", mic_fault, 1'b1);
        check("t6_stop_i2s", i2s_rst, 1'b1);
        check("t6_stop_busy", busy, 1'b1);
        tick();
        check("t6_idle_after", busy, 1'b0);
        pulse_start();
        check("t6_fault_clr", mic_fault, 1'b0);
        pulse_stop();
`else
        check("t6_fault_tied", mic_fault, 1'b0);
`endif

        // Randomised traffic against the reference model.
        #2 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        model_reset();
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            logic s, p, v, r;
            logic [15:0] d;
            s = ($urandom % 50) == 0;
            p = ($urandom % 90) == 0;
            v = $urandom % 2;
            d = 16'($urandom);
            r = ((c / 400) % 2 == 1) ? (($urandom % 8) == 0) : (($urandom % 4) != 0);
            start = s; stop = p; in_valid = v; in_sample = d; out_ready = r;
            compare_model();
            model_step(s, p, v, d, r);
            tick();
        end
        start = 1'b0; stop = 1'b0; in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
